// File: rtl/retire_trace_pkg.sv
// Shared definitions for the retire trace buffer: record kinds, capture FSM states and record layout.
// Defining RETIRE_TRACE_CYCLE_STAMP_EN adds a cycle stamp field to every record.
package retire_trace_pkg;

  // Record counters are carried at this width; the top's CNT_W must not exceed it.
  localparam int REC_CNT_W = 32;

  typedef enum logic [2:0] {
    KIND_NOP   = 3'd0,
    KIND_REG   = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_HALT  = 3'd4
  } recKindE;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    DONE    = 2'd2
  } traceStateE;

  typedef struct packed {
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    logic [REC_CNT_W-1:0] cycle;
`endif
    recKindE              kind;
    logic [REC_CNT_W-1:0] inum;
    logic [15:0]          pc;
    logic [3:0]           rd;
    logic [15:0]          value;
    logic [15:0]          addr;
  } traceRecT;

  localparam int REC_W = $bits(traceRecT);

  // A register write wins over halt, which wins over a store.
  function automatic recKindE classify(input logic regWrite, input logic memRead,
                                       input logic halt, input logic memWrite);
    recKindE kind;
    kind = KIND_NOP;
    if (regWrite) begin
      if (memRead) kind = KIND_LOAD;
      else         kind = KIND_REG;
    end else if (halt) begin
      kind = KIND_HALT;
    end else if (memWrite) begin
      kind = KIND_STORE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; pointers carry an extra MSB so full and empty differ.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count  = wrPtr - rdPtr;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdata  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset: the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: classifies retirements, numbers them, buffers records and runs the halt/watchdog FSM.
// Optional RETIRE_TRACE_CYCLE_STAMP_EN adds the rec_cycle output (cycle_count at push).
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_valid,
  input  logic [15:0]      ret_pc,
  input  logic [15:0]      ret_inst,
  input  logic             ret_regwrite,
  input  logic [3:0]       ret_reg,
  input  logic [15:0]      ret_wdata,
  input  logic             ret_memread,
  input  logic             ret_memwrite,
  input  logic [15:0]      ret_addr,
  input  logic [15:0]      ret_mdata,
  input  logic             ret_halt,
  output logic             cpu_stall,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [2:0]       rec_kind,
  output logic [CNT_W-1:0] rec_inum,
  output logic [15:0]      rec_pc,
  output logic [3:0]       rec_reg,
  output logic [15:0]      rec_value,
  output logic [15:0]      rec_addr,
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
  output logic [CNT_W-1:0] rec_cycle,
`endif
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout,
  output logic             done,
  output traceStateE       dbgState
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [AW:0]      LAST_ONE    = {{AW{1'b0}}, 1'b1};

  traceStateE       stateQ, stateD;
  logic [CNT_W-1:0] instQ, cycleQ;
  logic             timeoutQ, timeoutSet;
  logic             accept, pop;
  logic             fifoFull, fifoEmpty;
  logic [AW:0]      fifoCount;
  traceRecT         recIn, recRd, recOut;
  logic             unusedInst;

  // The instruction word is not part of the record.
  assign unusedInst = ^ret_inst;

  assign accept     = ret_valid && !fifoFull && (stateQ == RUN);
  assign pop        = !fifoEmpty && rec_ready;
  assign timeoutSet = !timeoutQ && (stateQ != DONE) && ((cycleQ + CNT_ONE) == TIMEOUT_VAL);

  always_comb begin
    recIn      = '0;
    recIn.kind = classify(ret_regwrite, ret_memread, ret_halt, ret_memwrite);
    recIn.inum = REC_CNT_W'(instQ);
    recIn.pc   = ret_pc;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    recIn.cycle = REC_CNT_W'(cycleQ);
`endif
    unique case (recIn.kind)
      KIND_REG: begin
        recIn.rd    = ret_reg;
        recIn.value = ret_wdata;
      end
      KIND_LOAD: begin
        recIn.rd    = ret_reg;
        recIn.value = ret_wdata;
        recIn.addr  = ret_addr;
      end
      KIND_STORE: begin
        recIn.value = ret_mdata;
        recIn.addr  = ret_addr;
      end
      default: ;
    endcase
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata (recIn),
    .rdata (recRd),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // The watchdog overrides every other transition and stops capture for good.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      RUN:     if (accept && (recIn.kind == KIND_HALT)) stateD = HALTING;
      HALTING: if (pop && (fifoCount == LAST_ONE)) stateD = DONE;
      DONE:    stateD = DONE;
      default: stateD = RUN;
    endcase
    if (timeoutSet) stateD = DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= RUN;
      instQ    <= '0;
      cycleQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept)          instQ    <= instQ + CNT_ONE;
      if (stateQ != DONE)  cycleQ   <= cycleQ + CNT_ONE;
      if (timeoutSet)      timeoutQ <= 1'b1;
    end
  end

  assign recOut      = fifoEmpty ? '0 : recRd;
  assign cpu_stall   = fifoFull;
  assign rec_valid   = !fifoEmpty;
  assign rec_kind    = recOut.kind;
  assign rec_inum    = recOut.inum[CNT_W-1:0];
  assign rec_pc      = recOut.pc;
  assign rec_reg     = recOut.rd;
  assign rec_value   = recOut.value;
  assign rec_addr    = recOut.addr;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
  assign rec_cycle   = recOut.cycle[CNT_W-1:0];
`endif
  assign inst_count  = instQ;
  assign cycle_count = cycleQ;
  assign timeout     = timeoutQ;
  assign done        = (stateQ == DONE) && fifoEmpty;
  assign dbgState    = stateQ;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer; a second instance with a 20-cycle watchdog covers the timeout path.
module tb_retire_trace_buffer;
  import retire_trace_pkg::*;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic ret_valid, ret_regwrite, ret_memread, ret_memwrite, ret_halt, rec_ready;
  logic [15:0] ret_pc, ret_inst, ret_wdata, ret_addr, ret_mdata;
  logic [3:0]  ret_reg;

  logic cpu_stall, rec_valid, timeout, done;
  logic [2:0] rec_kind;
  logic [CNT_W-1:0] rec_inum, inst_count, cycle_count;
  logic [15:0] rec_pc, rec_value, rec_addr;
  logic [3:0]  rec_reg;
  traceStateE  dbg_state;

  logic t_cpu_stall, t_rec_valid, t_timeout, t_done;
  logic [2:0] t_rec_kind;
  logic [CNT_W-1:0] t_rec_inum, t_inst_count, t_cycle_count;
  logic [15:0] t_rec_pc, t_rec_value, t_rec_addr;
  logic [3:0]  t_rec_reg;
  traceStateE  t_dbg_state;
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0] rec_cycle, t_rec_cycle;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(8), .CNT_W(CNT_W), .TIMEOUT_CYCLES(100000)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_regwrite(ret_regwrite), .ret_reg(ret_reg), .ret_wdata(ret_wdata),
    .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_addr(ret_addr),
    .ret_mdata(ret_mdata), .ret_halt(ret_halt), .cpu_stall(cpu_stall),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_value(rec_value), .rec_addr(rec_addr),
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    .rec_cycle(rec_cycle),
`endif
    .inst_count(inst_count), .cycle_count(cycle_count), .timeout(timeout), .done(done),
    .dbgState(dbg_state)
  );

  retire_trace_buffer #(.DEPTH(8), .CNT_W(CNT_W), .TIMEOUT_CYCLES(20)) dut_to (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_regwrite(ret_regwrite), .ret_reg(ret_reg), .ret_wdata(ret_wdata),
    .ret_memread(ret_memread), .ret_memwrite(ret_memwrite), .ret_addr(ret_addr),
    .ret_mdata(ret_mdata), .ret_halt(ret_halt), .cpu_stall(t_cpu_stall),
    .rec_valid(t_rec_valid), .rec_ready(rec_ready), .rec_kind(t_rec_kind), .rec_inum(t_rec_inum),
    .rec_pc(t_rec_pc), .rec_reg(t_rec_reg), .rec_value(t_rec_value), .rec_addr(t_rec_addr),
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
    .rec_cycle(t_rec_cycle),
`endif
    .inst_count(t_inst_count), .cycle_count(t_cycle_count), .timeout(t_timeout), .done(t_done),
    .dbgState(t_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_ret();
    ret_valid = 1'b0; ret_regwrite = 1'b0; ret_memread = 1'b0; ret_memwrite = 1'b0;
    ret_halt = 1'b0; ret_pc = '0; ret_inst = '0; ret_reg = '0; ret_wdata = '0;
    ret_addr = '0; ret_mdata = '0;
  endtask

  task automatic drive_ret(input logic rw, input logic mr, input logic mw, input logic h,
                           input logic [15:0] pc, input logic [3:0] rg,
                           input logic [15:0] wd, input logic [15:0] ad, input logic [15:0] md);
    ret_valid = 1'b1; ret_regwrite = rw; ret_memread = mr; ret_memwrite = mw; ret_halt = h;
    ret_pc = pc; ret_inst = pc ^ 16'hA5A5; ret_reg = rg; ret_wdata = wd; ret_addr = ad;
    ret_mdata = md;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_ret();
    rec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if ({cpu_stall, rec_valid, timeout, done} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {cpu_stall, rec_valid, timeout, done}); end
    checks++; if ({rec_kind, rec_reg, rec_pc, rec_value, rec_addr} !== 55'd0) begin errors++;
      $display("FAIL reset_fields: got %h expected 0", {rec_kind, rec_reg, rec_pc, rec_value, rec_addr}); end
    checks++; if ({rec_inum, inst_count, cycle_count} !== 96'd0) begin errors++;
      $display("FAIL reset_counts: got %h expected 0", {rec_inum, inst_count, cycle_count}); end
    checks++; if (dbg_state !== RUN) begin errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, RUN); end
    checks++; if ({t_cpu_stall, t_rec_valid, t_timeout, t_done, t_rec_kind, t_rec_reg, t_rec_pc,
                   t_rec_value, t_rec_addr, t_rec_inum, t_inst_count, t_cycle_count} !== 155'd0) begin
      errors++; $display("FAIL reset_wd_inst: got nonzero outputs, expected all 0"); end
  endtask

  task automatic test_sequence();
    logic [2:0]  ek [5];
    logic [15:0] ep [5];
    logic [3:0]  er [5];
    logic [15:0] ev [5];
    logic [15:0] ea [5];
    logic [87:0] got, want;
    ek = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd4};
    ep = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
    er = '{4'd3, 4'd2, 4'd0, 4'd0, 4'd0};
    ev = '{16'h1234, 16'h00AA, 16'hBEEF, 16'h0000, 16'h0000};
    ea = '{16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0000};
    do_reset();
    rec_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        got  = {rec_valid, rec_kind, rec_inum, rec_pc, rec_reg, rec_value, rec_addr};
        want = {1'b1, ek[i-1], 32'(i-1), ep[i-1], er[i-1], ev[i-1], ea[i-1]};
        checks++; if (got !== want) begin errors++;
          $display("FAIL seq_rec%0d: got %h expected %h", i - 1, got, want); end
`ifdef RETIRE_TRACE_CYCLE_STAMP_EN
        checks++; if (rec_cycle !== 32'(i)) begin errors++;
          $display("FAIL seq_cycle%0d: got %0d expected %0d", i - 1, rec_cycle, i); end
`endif
      end
      case (i)
        0: drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd3, 16'h1234, 16'h5555, 16'h0000);
        1: drive_ret(1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 4'd2, 16'h00AA, 16'h0010, 16'h0000);
        2: drive_ret(1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 4'd7, 16'h0000, 16'h0020, 16'hBEEF);
        3: drive_ret(1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 4'd0, 16'h9999, 16'h0000, 16'h0000);
        4: drive_ret(1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 4'd0, 16'h0000, 16'h7777, 16'h0000);
        default: begin
          clear_ret();
          checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL seq_done_early: got %b expected 0", done); end
        end
      endcase
    end
    @(negedge clk);
    checks++; if ({done, rec_valid, inst_count} !== {1'b1, 1'b0, 32'd5}) begin errors++;
      $display("FAIL seq_done: got done=%b valid=%b inst=%0d expected 1 0 5", done, rec_valid, inst_count); end
    checks++; if (dbg_state !== DONE) begin errors++;
      $display("FAIL seq_state: got %0d expected %0d", dbg_state, DONE); end
  endtask

  task automatic test_full();
    logic [15:0] exp;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        checks++; if (cpu_stall !== 1'b0) begin errors++;
          $display("FAIL full_stall7: got %b expected 0", cpu_stall); end
      end
      drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + 2 * i), 4'd1, 16'(i * 17), 16'h0, 16'h0);
      exp_q.push_back(16'(16'h0100 + 2 * i));
    end
    @(negedge clk);
    checks++; if ({cpu_stall, inst_count, rec_pc} !== {1'b1, 32'd8, 16'h0100}) begin errors++;
      $display("FAIL full_stall8: got stall=%b inst=%0d pc=%h expected 1 8 0100", cpu_stall, inst_count, rec_pc); end
    drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0200, 4'd9, 16'h0900, 16'h0, 16'h0);
    exp_q.push_back(16'h0200);
    @(negedge clk);
    checks++; if ({cpu_stall, inst_count, rec_pc} !== {1'b1, 32'd8, 16'h0100}) begin errors++;
      $display("FAIL full_hold: got stall=%b inst=%0d pc=%h expected 1 8 0100", cpu_stall, inst_count, rec_pc); end
    rec_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin
        checks++; if ({cpu_stall, inst_count} !== {1'b0, 32'd8}) begin errors++;
          $display("FAIL full_pop_stall: got stall=%b inst=%0d expected 0 8", cpu_stall, inst_count); end
      end
      if (i == 2) begin
        checks++; if (inst_count !== 32'd9) begin errors++;
          $display("FAIL full_ninth: got %0d expected 9", inst_count); end
        clear_ret();
      end
      exp = exp_q.pop_front();
      checks++; if ({rec_valid, rec_pc, rec_inum} !== {1'b1, exp, 32'(i)}) begin errors++;
        $display("FAIL full_drain%0d: got v=%b pc=%h inum=%0d expected 1 %h %0d", i, rec_valid, rec_pc, rec_inum, exp, i); end
    end
    @(negedge clk);
    checks++; if ({rec_valid, cpu_stall} !== 2'b00) begin errors++;
      $display("FAIL full_empty: got %b expected 00", {rec_valid, cpu_stall}); end
  endtask

  task automatic test_priority();
    do_reset();
    rec_ready = 1'b1;
    @(negedge clk);
    drive_ret(1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 4'd5, 16'h0042, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if ({rec_kind, rec_reg, rec_value} !== {3'd1, 4'd5, 16'h0042}) begin errors++;
      $display("FAIL prio_kind: got kind=%0d reg=%0d val=%h expected 1 5 0042", rec_kind, rec_reg, rec_value); end
    checks++; if (dbg_state !== RUN) begin errors++;
      $display("FAIL prio_state: got %0d expected %0d", dbg_state, RUN); end
    drive_ret(1'b0, 1'b0, 1'b0, 1'b0, 16'h0032, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    clear_ret();
    checks++; if ({inst_count, rec_kind, rec_pc} !== {32'd2, 3'd0, 16'h0032}) begin errors++;
      $display("FAIL prio_next: got inst=%0d kind=%0d pc=%h expected 2 0 0032", inst_count, rec_kind, rec_pc); end
  endtask

  task automatic test_after_halt();
    do_reset();
    @(negedge clk);
    drive_ret(1'b0, 1'b0, 1'b0, 1'b1, 16'h0080, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if ({dbg_state, inst_count, cycle_count} !== {HALTING, 32'd1, 32'd2}) begin errors++;
      $display("FAIL halt_enter: got st=%0d inst=%0d cyc=%0d expected 1 1 2", dbg_state, inst_count, cycle_count); end
    drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0082, 4'd6, 16'h1111, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if ({inst_count, rec_kind, rec_pc} !== {32'd1, 3'd4, 16'h0080}) begin errors++;
      $display("FAIL halt_ignore: got inst=%0d kind=%0d pc=%h expected 1 4 0080", inst_count, rec_kind, rec_pc); end
    rec_ready = 1'b1;
    @(negedge clk);
    checks++; if ({done, rec_valid, inst_count, cycle_count} !== {1'b1, 1'b0, 32'd1, 32'd4}) begin errors++;
      $display("FAIL halt_done: got done=%b v=%b inst=%0d cyc=%0d expected 1 0 1 4", done, rec_valid, inst_count, cycle_count); end
    @(negedge clk);
    checks++; if ({rec_valid, inst_count, cycle_count} !== {1'b0, 32'd1, 32'd4}) begin errors++;
      $display("FAIL halt_frozen: got v=%b inst=%0d cyc=%0d expected 0 1 4", rec_valid, inst_count, cycle_count); end
    clear_ret();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      case (k)
        0, 1, 2: drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0060 + 2 * k), 4'd2, 16'(k), 16'h0, 16'h0);
        3: clear_ret();
        18: begin
          checks++; if ({t_timeout, t_cycle_count, t_dbg_state} !== {1'b0, 32'd19, RUN}) begin errors++;
            $display("FAIL wd_before: got to=%b cyc=%0d st=%0d expected 0 19 0", t_timeout, t_cycle_count, t_dbg_state); end
          drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0070, 4'd2, 16'h0003, 16'h0, 16'h0);
        end
        19: begin
          checks++; if ({t_timeout, t_cycle_count, t_inst_count} !== {1'b1, 32'd20, 32'd4}) begin errors++;
            $display("FAIL wd_fire: got to=%b cyc=%0d inst=%0d expected 1 20 4", t_timeout, t_cycle_count, t_inst_count); end
          checks++; if ({t_dbg_state, t_done} !== {DONE, 1'b0}) begin errors++;
            $display("FAIL wd_state: got st=%0d done=%b expected 2 0", t_dbg_state, t_done); end
          drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0072, 4'd2, 16'h0004, 16'h0, 16'h0);
        end
        20: begin
          checks++; if ({t_inst_count, t_cycle_count, t_rec_valid, t_rec_inum} !== {32'd4, 32'd20, 1'b1, 32'd0}) begin
            errors++; $display("FAIL wd_nopush: got inst=%0d cyc=%0d v=%b inum=%0d expected 4 20 1 0",
                               t_inst_count, t_cycle_count, t_rec_valid, t_rec_inum); end
          clear_ret();
          rec_ready = 1'b1;
        end
        21, 22, 23: begin
          checks++; if (t_rec_inum !== 32'(k - 20)) begin errors++;
            $display("FAIL wd_drain: got %0d expected %0d", t_rec_inum, k - 20); end
        end
        24: begin
          checks++; if ({t_done, t_rec_valid, t_timeout} !== 3'b101) begin errors++;
            $display("FAIL wd_done: got %b expected 101", {t_done, t_rec_valid, t_timeout}); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0040 + 2 * k), 4'd1, 16'(k), 16'h0, 16'h0);
    end
    @(negedge clk);
    clear_ret();
    checks++; if ({rec_valid, inst_count} !== {1'b1, 32'd5}) begin errors++;
      $display("FAIL mid_fill: got v=%b inst=%0d expected 1 5", rec_valid, inst_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({cpu_stall, rec_valid, timeout, done, rec_pc, rec_value, rec_addr, rec_inum} !== 84'd0) begin
      errors++; $display("FAIL mid_async: got v=%b pc=%h inum=%0d expected all 0", rec_valid, rec_pc, rec_inum); end
    checks++; if ({inst_count, cycle_count} !== 64'd0) begin errors++;
      $display("FAIL mid_counts: got inst=%0d cyc=%0d expected 0 0", inst_count, cycle_count); end
    @(negedge clk);
    rst = 1'b1;
    drive_ret(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 4'd4, 16'h0ABC, 16'h0, 16'h0);
    @(negedge clk);
    clear_ret();
    checks++; if ({rec_valid, rec_inum, rec_pc, inst_count} !== {1'b1, 32'd0, 16'h0050, 32'd1}) begin errors++;
      $display("FAIL mid_restart: got v=%b inum=%0d pc=%h inst=%0d expected 1 0 0050 1", rec_valid, rec_inum, rec_pc, inst_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    rec_ready = 1'b0;
    clear_ret();
    test_reset();
    test_sequence();
    test_full();
    test_priority();
    test_after_halt();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
